multicycle_controller: RTL and testbench

Control unit that sequences the ARM datapath as a multicycle machine. One instruction executes over 3–5 clock cycles. A Moore FSM drives the mux selects and write enables for the shared-memory multicycle datapath. A condition unit holds the NZCV flags and gates all architectural writes. The block sits beside the datapath: it takes the instruction register contents and the ALU flags, and returns every control signal.

---
 rtl/multicycle_controller_pkg.sv | 71 +++++++
 rtl/multicycle_controller_if.sv | 30 +++
 rtl/multicycle_controller_cond_unit.sv | 57 +++++
 rtl/multicycle_controller.sv | 142 ++++++++++++++
 tb/tb_multicycle_controller.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle ARM controller: FSM states,
// datapath mux encodings, instruction field codes and the ALU command decoder.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  typedef struct packed {
    logic       legal;
    logic [1:0] ctrl;
  } alu_dec_t;

  // Unsupported commands execute as ADD but must never write a register.
  function automatic alu_dec_t alu_decode(input logic [3:0] cmd);
    alu_dec_t d;
    d.legal = 1'b1;
    d.ctrl  = ALU_ADD;
    case (cmd)
      4'b0100: d.ctrl = ALU_ADD;
      4'b0010: d.ctrl = ALU_SUB;
      4'b0000: d.ctrl = ALU_AND;
      4'b1100: d.ctrl = ALU_ORR;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Signal bundle between the multicycle controller (slave) and the datapath
// that feeds it the instruction and ALU flags (master).
interface multicycle_controller_if;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic [1:0]  ResultSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic        RegWrite;
  logic [1:0]  ALUControl;
  logic [3:0]  Flags;

  modport master (
    output Instr, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegSrc, RegWrite, ALUControl, Flags
  );

  modport slave (
    input  Instr, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegSrc, RegWrite, ALUControl, Flags
  );
endinterface

// File: rtl/multicycle_controller_cond_unit.sv
// NZCV flag register plus the condition evaluator; the pass/fail result is
// captured once per instruction so later cycles see a stable gate.
module cond_unit
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       CondLatch,
  output logic       CondExQ,
  output logic [3:0] Flags
);

  logic       n, z, c, v;
  logic       cond_ex;
  logic [1:0] flag_en;

  assign {n, z, c, v} = Flags;

  always_comb begin
    cond_ex = 1'b1;
    case (Cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      default: cond_ex = 1'b1;
    endcase
  end

  // A failed condition must also leave the flags untouched.
  assign flag_en = FlagW & {2{CondExQ}};

  always_ff @(posedge clk) begin
    if (reset) begin
      Flags   <= 4'b0000;
      CondExQ <= 1'b0;
    end else begin
      if (flag_en[1]) Flags[3:2] <= ALUFlags[3:2];
      if (flag_en[0]) Flags[1:0] <= ALUFlags[1:0];
      if (CondLatch)  CondExQ    <= cond_ex;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM and ALU decoder sequencing a shared-memory multicycle ARM datapath;
// architectural writes are gated by the condition result latched in DECODE.
module multicycle_controller
  import multicycle_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.slave bus
);

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_instr;

  assign cond  = bus.Instr[31:28];
  assign op    = bus.Instr[27:26];
  assign funct = bus.Instr[25:20];
  assign rd    = bus.Instr[15:12];
  assign unused_instr = ^{bus.Instr[19:16], bus.Instr[11:0]};

  state_t     state, state_next;
  logic       next_pc, branch, mem_w, reg_w, ir_write, adr_src, alu_src_a, alu_op;
  logic [1:0] result_src, alu_src_b;
  logic [1:0] alu_control;
  logic [1:0] flag_w;
  logic       pcs;
  logic       cond_ex_q;
  alu_dec_t   dp_dec;

  assign dp_dec = alu_decode(funct[4:1]);

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    next_pc    = 1'b0;
    branch     = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_op     = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_b  = SRCB_RD2;
    case (state)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        next_pc    = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        case (op)
          OP_MEM:  state_next = S_MEMADR;
          OP_DP:   state_next = funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_next = S_BRANCH;
          default: state_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_b  = SRCB_EXTIMM;
        state_next = funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_w      = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_w      = 1'b1;
        state_next = S_FETCH;
      end
      S_EXECUTER: begin
        alu_op     = 1'b1;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_b  = SRCB_EXTIMM;
        alu_op     = 1'b1;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w      = dp_dec.legal;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_b  = SRCB_EXTIMM;
        result_src = RES_ALURESULT;
        branch     = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  assign alu_control = alu_op ? dp_dec.ctrl : ALU_ADD;
  assign flag_w[1]   = alu_op & funct[0];
  assign flag_w[0]   = alu_op & funct[0] &
                       ((alu_control == ALU_ADD) | (alu_control == ALU_SUB));
  assign pcs         = branch | (reg_w & (rd == 4'b1111));

  cond_unit u_cond (
    .clk       (clk),
    .reset     (reset),
    .Cond      (cond),
    .ALUFlags  (bus.ALUFlags),
    .FlagW     (flag_w),
    .CondLatch (state == S_DECODE),
    .CondExQ   (cond_ex_q),
    .Flags     (bus.Flags)
  );

  // Write strobes are held low during reset so an aborted instruction leaves no trace.
  assign bus.PCWrite    = ~reset & (next_pc | (pcs & cond_ex_q));
  assign bus.RegWrite   = ~reset & reg_w & cond_ex_q;
  assign bus.MemWrite   = ~reset & mem_w & cond_ex_q;
  assign bus.IRWrite    = ~reset & ir_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {op == OP_MEM, op == OP_BR};

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed instruction sequences for the multicycle controller; per-cycle expected
// control words go into a scoreboard queue that a negedge monitor drains.
module tb_multicycle_controller;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic [19:0] v;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [19:0] mon_act;
  int          total = 0;
  int          bad   = 0;

  logic [31:0] cur_instr = 32'h0;
  logic [3:0]  cur_alu   = 4'b1001;
  logic        cur_rst   = 1'b1;

  // Drive one cycle of inputs just after the edge and queue that cycle's expected outputs.
  task automatic cyc(input string name, input logic pcw, input logic adr, input logic memw,
                     input logic irw, input logic [1:0] rs, input logic srca,
                     input logic [1:0] srcb, input logic regw, input logic [1:0] alc,
                     input logic [3:0] flg);
    exp_t e;
    @(posedge clk);
    #1;
    bus.Instr    = cur_instr;
    bus.ALUFlags = cur_alu;
    reset        = cur_rst;
    e.name = name;
    e.v = {pcw, adr, memw, irw, rs, srca, srcb, cur_instr[27:26],
           cur_instr[27:26] == 2'b01, cur_instr[27:26] == 2'b10,
           regw, alc, flg};
    sb.push_back(e);
  endtask

  task automatic fetch(input string name, input logic [3:0] flg);
    cyc(name, 1, 0, 0, 1, 2'b10, 1, 2'b10, 0, 2'b00, flg);
  endtask

  task automatic decode(input string name, input logic [3:0] flg);
    cyc(name, 0, 0, 0, 0, 2'b10, 1, 2'b10, 0, 2'b00, flg);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e   = sb.pop_front();
      mon_act = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                 bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.RegSrc, bus.RegWrite,
                 bus.ALUControl, bus.Flags};
      total++;
      if (mon_act !== mon_e.v) begin
        bad++;
        $display("FAIL %s: got %b required %b", mon_e.name, mon_act, mon_e.v);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    bus.Instr    = 32'h0;
    bus.ALUFlags = 4'b1001;
    reset        = 1'b1;

    // Reset held: FETCH outputs with every write strobe forced low.
    cur_rst = 1'b1;
    cyc("rst_hold", 0, 0, 0, 0, 2'b10, 1, 2'b10, 0, 2'b00, 4'b0000);
    cur_rst = 1'b0;

    // ADD R1,R2,R3
    cur_instr = 32'hE0821003;
    fetch ("add_fetch", 4'b0000);
    decode("add_decode", 4'b0000);
    cyc("add_execr", 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 4'b0000);
    cyc("add_aluwb", 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 2'b00, 4'b0000);

    // SUBS R0,R0,#1 producing NZCV=0110
    cur_instr = 32'hE2500001;
    fetch ("subs_fetch", 4'b0000);
    decode("subs_decode", 4'b0000);
    cur_alu = 4'b0110;
    cyc("subs_execi", 0, 0, 0, 0, 2'b00, 0, 2'b01, 0, 2'b01, 4'b0000);
    cur_alu = 4'b1001;
    cyc("subs_aluwb", 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 2'b00, 4'b0110);

    // BEQ taken on Z=1
    cur_instr = 32'h0A000002;
    fetch ("beq_fetch", 4'b0110);
    decode("beq_decode", 4'b0110);
    cyc("beq_branch", 1, 0, 0, 0, 2'b10, 0, 2'b01, 0, 2'b00, 4'b0110);

    // SUBS again, result NZCV=0010 so Z clears
    cur_instr = 32'hE2500001;
    fetch ("subs2_fetch", 4'b0110);
    decode("subs2_decode", 4'b0110);
    cur_alu = 4'b0010;
    cyc("subs2_execi", 0, 0, 0, 0, 2'b00, 0, 2'b01, 0, 2'b01, 4'b0110);
    cur_alu = 4'b1001;
    cyc("subs2_aluwb", 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 2'b00, 4'b0010);

    // LDREQ with Z=0: full five cycles, load suppressed
    cur_instr = 32'h05901000;
    fetch ("ldreq_fetch", 4'b0010);
    decode("ldreq_decode", 4'b0010);
    cyc("ldreq_memadr", 0, 0, 0, 0, 2'b00, 0, 2'b01, 0, 2'b00, 4'b0010);
    cyc("ldreq_memread", 0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 4'b0010);
    cyc("ldreq_memwb", 0, 0, 0, 0, 2'b01, 0, 2'b00, 0, 2'b00, 4'b0010);

    // STR: single MemWrite cycle
    cur_instr = 32'hE5801004;
    fetch ("str_fetch", 4'b0010);
    decode("str_decode", 4'b0010);
    cyc("str_memadr", 0, 0, 0, 0, 2'b00, 0, 2'b01, 0, 2'b00, 4'b0010);
    cyc("str_memwrite", 0, 1, 1, 0, 2'b00, 0, 2'b00, 0, 2'b00, 4'b0010);

    // ADD with Rd=PC
    cur_instr = 32'hE08FF003;
    fetch ("addpc_fetch", 4'b0010);
    decode("addpc_decode", 4'b0010);
    cyc("addpc_execr", 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 4'b0010);
    cyc("addpc_aluwb", 1, 0, 0, 0, 2'b00, 0, 2'b00, 1, 2'b00, 4'b0010);

    // Unsupported command 0001: runs as ADD, no register write
    cur_instr = 32'hE0200003;
    fetch ("ill_fetch", 4'b0010);
    decode("ill_decode", 4'b0010);
    cyc("ill_execr", 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 4'b0010);
    cyc("ill_aluwb", 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 4'b0010);

    // AND R2,R1,R2
    cur_instr = 32'hE0012002;
    fetch ("and_fetch", 4'b0010);
    decode("and_decode", 4'b0010);
    cyc("and_execr", 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b10, 4'b0010);
    cyc("and_aluwb", 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 2'b00, 4'b0010);

    // ORRS: only NZ update, CV keep 10
    cur_instr = 32'hE1910002;
    fetch ("orrs_fetch", 4'b0010);
    decode("orrs_decode", 4'b0010);
    cur_alu = 4'b1111;
    cyc("orrs_execr", 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b11, 4'b0010);
    cur_alu = 4'b1001;
    cyc("orrs_aluwb", 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 2'b00, 4'b1110);

    // Op=11 executes as a two-cycle NOP
    cur_instr = 32'hEC000000;
    fetch ("op11_fetch", 4'b1110);
    decode("op11_decode", 4'b1110);

    // LDR aborted by reset in MEMREAD
    cur_instr = 32'hE5901000;
    fetch ("ldr_fetch", 4'b1110);
    decode("ldr_decode", 4'b1110);
    cyc("ldr_memadr", 0, 0, 0, 0, 2'b00, 0, 2'b01, 0, 2'b00, 4'b1110);
    cur_rst = 1'b1;
    cyc("ldr_memread_rst", 0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 4'b1110);
    cur_rst = 1'b0;

    // Recovery: fresh ADD starts in FETCH with cleared flags
    cur_instr = 32'hE0821003;
    fetch ("post_fetch", 4'b0000);
    decode("post_decode", 4'b0000);
    cyc("post_execr", 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 4'b0000);
    cyc("post_aluwb", 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 2'b00, 4'b0000);

    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending required 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
